// File: rtl/mux_seq_pkg.sv
// Shared types and constants for the mux select sequencer that feeds the 8:1 mux tree.
package mux_seq_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned HOLD_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage : mux_seq_pkg

// File: rtl/mux_select_sequencer.sv
// Accepts a byte, steps the mux select through all eight inputs and returns the
// sampled mux output as a strobed serial bit stream.
module mux_select_sequencer
  import mux_seq_pkg::*;
#(
  parameter bit          MSB_FIRST   = 1'b0,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              abort,
  output logic [DATA_W-1:0] d,
  output logic [SEL_W-1:0]  sel,
  output logic              bit_valid,
  input  logic              mux_y,
  output logic              ser_bit,
  output logic              ser_valid,
  output logic              done
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
    $error("HOLD_CYCLES must be within 1..15");
  end

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SEL_W-1:0]  SEL_START = MSB_FIRST ? '1 : '0;
  localparam logic [SEL_W-1:0]  BIT_LAST  = '1;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  d_q, d_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               bit_valid_q, bit_valid_d;
  logic               ser_bit_q, ser_bit_d;
  logic               ser_valid_q, ser_valid_d;
  logic               done_q, done_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [SEL_W-1:0]   bit_cnt_q, bit_cnt_d;

  assign load_ready = (state_q == IDLE) && rst_n;

  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    sel_d       = sel_q;
    bit_valid_d = bit_valid_q;
    ser_bit_d   = ser_bit_q;
    ser_valid_d = 1'b0;
    done_d      = 1'b0;
    hold_d      = hold_q;
    bit_cnt_d   = bit_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          state_d     = SCAN;
          d_d         = load_data;
          sel_d       = SEL_START;
          bit_valid_d = 1'b1;
          hold_d      = '0;
          bit_cnt_d   = '0;
        end
      end
      SCAN: begin
        // abort outranks a coincident sample: no strobe, no done
        if (abort) begin
          state_d     = IDLE;
          sel_d       = '0;
          bit_valid_d = 1'b0;
          hold_d      = '0;
          bit_cnt_d   = '0;
        end else if (hold_q == HOLD_LAST) begin
          ser_bit_d   = mux_y;
          ser_valid_d = 1'b1;
          hold_d      = '0;
          if (bit_cnt_q == BIT_LAST) begin
            state_d     = IDLE;
            done_d      = 1'b1;
            bit_valid_d = 1'b0;
            sel_d       = '0;
            bit_cnt_d   = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            sel_d     = MSB_FIRST ? sel_q - 1'b1 : sel_q + 1'b1;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      d_q         <= '0;
      sel_q       <= '0;
      bit_valid_q <= 1'b0;
      ser_bit_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      done_q      <= 1'b0;
      hold_q      <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      sel_q       <= sel_d;
      bit_valid_q <= bit_valid_d;
      ser_bit_q   <= ser_bit_d;
      ser_valid_q <= ser_valid_d;
      done_q      <= done_d;
      hold_q      <= hold_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign d         = d_q;
  assign sel       = sel_q;
  assign bit_valid = bit_valid_q;
  assign ser_bit   = ser_bit_q;
  assign ser_valid = ser_valid_q;
  assign done      = done_q;

endmodule : mux_select_sequencer

// File: tb/tb_mux_select_sequencer.sv
// Bench for mux_select_sequencer: three configurations, each closed through an 8:1 mux tree.
module tb_mux_select_sequencer;

  logic       clk;
  logic       rst_n;
  logic       load_valid;
  logic [7:0] load_data;
  logic       abort;

  logic       rdy_w [3];
  logic [7:0] d_w   [3];
  logic [2:0] sel_w [3];
  logic       bv_w  [3];
  logic       y_w   [3];
  logic       sb_w  [3];
  logic       sv_w  [3];
  logic       dn_w  [3];

  int n_tests = 0;
  int n_fail  = 0;
  int cur     = 0;

  // three levels of 2:1 muxes: s0 pairs inputs, s1 pairs those, s2 picks the half
  function automatic logic mux8(input logic [7:0] din, input logic [2:0] s);
    logic [3:0] l1;
    logic [1:0] l2;
    for (int i = 0; i < 4; i++) l1[i] = s[0] ? din[2*i+1] : din[2*i];
    for (int j = 0; j < 2; j++) l2[j] = s[1] ? l1[2*j+1] : l1[2*j];
    return s[2] ? l2[1] : l2[0];
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_mux
    assign y_w[g] = mux8(d_w[g], sel_w[g]);
  end

  mux_select_sequencer #(.MSB_FIRST(1'b0), .HOLD_CYCLES(1)) u_lsb1 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(rdy_w[0]),
    .load_data(load_data), .abort(abort), .d(d_w[0]), .sel(sel_w[0]),
    .bit_valid(bv_w[0]), .mux_y(y_w[0]), .ser_bit(sb_w[0]), .ser_valid(sv_w[0]),
    .done(dn_w[0]));

  mux_select_sequencer #(.MSB_FIRST(1'b1), .HOLD_CYCLES(1)) u_msb1 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(rdy_w[1]),
    .load_data(load_data), .abort(abort), .d(d_w[1]), .sel(sel_w[1]),
    .bit_valid(bv_w[1]), .mux_y(y_w[1]), .ser_bit(sb_w[1]), .ser_valid(sv_w[1]),
    .done(dn_w[1]));

  mux_select_sequencer #(.MSB_FIRST(1'b0), .HOLD_CYCLES(3)) u_lsb3 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(rdy_w[2]),
    .load_data(load_data), .abort(abort), .d(d_w[2]), .sel(sel_w[2]),
    .bit_valid(bv_w[2]), .mux_y(y_w[2]), .ser_bit(sb_w[2]), .ser_valid(sv_w[2]),
    .done(dn_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       lv;
    logic [7:0] data;
    logic [2:0] sel;
    logic       bv;
    logic       sv;
    logic       sb;
    logic       dn;
    logic       rdy;
  } vec_t;

  vec_t tbl [10];

  // per-cycle trace; index c = state visible after the (c-1)-th edge past acceptance
  logic [2:0] t_sel [64];
  logic [7:0] t_d   [64];
  logic       t_bv  [64];
  logic       t_sv  [64];
  logic       t_sb  [64];
  logic       t_dn  [64];
  logic       t_rdy [64];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic reset_all();
    load_valid = 1'b0;
    abort      = 1'b0;
    rst_n      = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic capture(input int n, input bit hold_lv, input logic [7:0] second,
                         input int abort_c, input int rst_c);
    for (int c = 1; c <= n; c++) begin
      tick();
      t_sel[c] = sel_w[cur];
      t_d[c]   = d_w[cur];
      t_bv[c]  = bv_w[cur];
      t_sv[c]  = sv_w[cur];
      t_sb[c]  = sb_w[cur];
      t_dn[c]  = dn_w[cur];
      t_rdy[c] = rdy_w[cur];
      if (c == 1) begin
        if (hold_lv) load_data = second;
        else load_valid = 1'b0;
      end
      abort = (c == abort_c);
      rst_n = !(c == rst_c);
    end
    abort      = 1'b0;
    rst_n      = 1'b1;
    load_valid = 1'b0;
  endtask

  task automatic analyze(input int from, input int to, output int cnt,
                         output logic [15:0] bits, output int first_done,
                         output int n_done);
    cnt = 0; bits = '0; first_done = -1; n_done = 0;
    for (int c = from; c <= to; c++) begin
      if (t_sv[c]) begin
        if (cnt < 16) bits[cnt] = t_sb[c];
        cnt++;
      end
      if (t_dn[c]) begin
        if (first_done < 0) first_done = c;
        n_done++;
      end
    end
  endtask

  int          cnt, fdone, ndone, acc;
  logic [15:0] bits;

  initial begin
    tbl[0] = '{1'b1, 8'h01, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // reset state, all three configurations
    rst_n = 1'b0; load_valid = 1'b1; load_data = 8'hFF; abort = 1'b0;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", i, rdy_w[i], 0);
      chk("rst_d", i, d_w[i], 0);
      chk("rst_sel", i, sel_w[i], 0);
      chk("rst_outs", i, {bv_w[i], sb_w[i], sv_w[i], dn_w[i]}, 0);
    end
    load_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 0, rdy_w[0], 1);

    // LSB-first HOLD=1, load 0x01, table-driven
    cur = 0;
    for (int i = 0; i < 10; i++) begin
      load_valid = tbl[i].lv;
      load_data  = tbl[i].data;
      tick();
      chk("t1_sel", i, sel_w[0], tbl[i].sel);
      chk("t1_bv", i, bv_w[0], tbl[i].bv);
      chk("t1_sv", i, sv_w[0], tbl[i].sv);
      chk("t1_sb", i, sb_w[0], tbl[i].sb);
      chk("t1_done", i, dn_w[0], tbl[i].dn);
      chk("t1_ready", i, rdy_w[0], tbl[i].rdy);
    end
    chk("t1_d_held", 0, d_w[0], 8'h01);

    // MSB-first, load 0xA5
    reset_all();
    cur = 1; load_valid = 1'b1; load_data = 8'hA5;
    capture(12, 1'b0, 8'h00, 0, 0);
    for (int c = 1; c <= 8; c++) chk("t2_sel", c, t_sel[c], 8 - c);
    chk("t2_sel_home", 9, t_sel[9], 0);
    analyze(1, 12, cnt, bits, fdone, ndone);
    chk("t2_pulses", 0, cnt, 8);
    chk("t2_stream", 0, bits[7:0], 8'hA5);
    chk("t2_done_at", 0, fdone, 9);
    chk("t2_n_done", 0, ndone, 1);

    // HOLD=3, load 0x3C
    reset_all();
    cur = 2; load_valid = 1'b1; load_data = 8'h3C;
    capture(30, 1'b0, 8'h00, 0, 0);
    for (int c = 1; c <= 24; c++) chk("t3_sel", c, t_sel[c], (c - 1) / 3);
    for (int c = 1; c <= 30; c++)
      chk("t3_sv", c, t_sv[c], (c >= 4 && c <= 25 && ((c - 4) % 3 == 0)) ? 1 : 0);
    analyze(1, 30, cnt, bits, fdone, ndone);
    chk("t3_pulses", 0, cnt, 8);
    chk("t3_stream", 0, bits[7:0], 8'h3C);
    chk("t3_done_at", 0, fdone, 25);

    // back-to-back with load_valid held high: 0xF0 then 0x0F
    reset_all();
    cur = 0; load_valid = 1'b1; load_data = 8'hF0;
    capture(18, 1'b1, 8'h0F, 0, 0);
    analyze(1, 18, cnt, bits, fdone, ndone);
    chk("t4_pulses", 0, cnt, 16);
    chk("t4_stream", 0, bits, 16'b0000_1111_1111_0000);
    chk("t4_gap", 10, t_sv[10], 0);
    chk("t4_done_at", 0, fdone, 9);
    chk("t4_n_done", 0, ndone, 2);
    chk("t4_ready_done", 9, t_rdy[9], 1);
    chk("t4_d_second", 10, t_d[10], 8'h0F);
    acc = 0;
    for (int c = 1; c <= 17; c++) if (c != 9 && t_rdy[c]) acc++;
    chk("t4_ready_busy", 0, acc, 0);

    // abort in the sample cycle of bit 4
    reset_all();
    cur = 0; load_valid = 1'b1; load_data = 8'hFF;
    capture(14, 1'b0, 8'h00, 5, 0);
    analyze(1, 14, cnt, bits, fdone, ndone);
    chk("t5_pulses", 0, cnt, 4);
    chk("t5_n_done", 0, ndone, 0);
    chk("t5_ready", 6, t_rdy[6], 1);
    chk("t5_sel", 6, t_sel[6], 0);
    chk("t5_bv", 6, t_bv[6], 0);
    chk("t5_d_kept", 6, t_d[6], 8'hFF);

    // synchronous reset mid-scan at bit 2, then a fresh load of 0x80
    reset_all();
    cur = 0; load_valid = 1'b1; load_data = 8'hFF;
    capture(10, 1'b0, 8'h00, 0, 3);
    chk("t6_sb_before", 3, t_sb[3], 1);
    chk("t6_zero", 4, {t_d[4], t_sel[4], t_bv[4], t_sb[4], t_sv[4], t_dn[4], t_rdy[4]}, 0);
    analyze(1, 10, cnt, bits, fdone, ndone);
    chk("t6_n_done", 0, ndone, 0);
    load_valid = 1'b1; load_data = 8'h80;
    capture(10, 1'b0, 8'h00, 0, 0);
    analyze(1, 10, cnt, bits, fdone, ndone);
    chk("t6_pulses", 0, cnt, 8);
    chk("t6_stream", 0, bits[7:0], 8'h80);
    chk("t6_done_at", 0, fdone, 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mux_select_sequencer
